// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared types, constants and helpers for the programmable
//               bit-serial sequence detector (seq_det_ctrl / seq_det_match).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  // Controller state: detection disarmed (IDLE) or armed (RUN)
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Default maximum pattern length in bits
  localparam int unsigned C_MAX_LEN_DEF = 8;

  // Width of a pattern-length field able to hold the value MAX_LEN itself
  localparam int unsigned C_LEN_W_DEF = $clog2(C_MAX_LEN_DEF) + 1;

  // A pattern length is usable when it spans at least two bits and fits
  // inside the pattern register.
  function automatic logic len_legal(input int unsigned len,
                                     input int unsigned max_len);
    return (len >= 2) && (len <= max_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_match.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_match
// Description : History shift register, fill counter and variable-length
//               comparator. Produces a combinational (Mealy) match flag for
//               the bit currently presented on `in`.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = C_MAX_LEN_DEF,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               clr,
  input  logic               en,
  input  logic               in,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               match
);

  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_primed;
  logic               w_equal;

  // The newest bit sits at position 0, so the window lines up with the
  // pattern layout where bit [len-1] is the first bit received.
  assign w_window = {r_hist, in};

  // Only the low `len` bits of the window take part in the compare
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign w_mask[i] = (len > LEN_W'(i));
  end

  // Enough earlier bits are present when fill + current bit covers len
  assign w_primed = ((LEN_W + 1)'(r_fill) + (LEN_W + 1)'(1)) >= (LEN_W + 1)'(len);
  assign w_equal  = (((w_window ^ pattern) & w_mask) == '0);
  assign match    = en & w_primed & w_equal;

  // History shifts on every qualified bit; fill saturates at len and
  // restarts after a non-overlapping match so used bits cannot be reused.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (en) begin
      r_hist <= w_window[MAX_LEN-2:0];
      if (match && !overlap) begin
        r_fill <= '0;
      end else if (r_fill < len) begin
        r_fill <= r_fill + LEN_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl
// Description : Programmable controller around a bit-serial Mealy sequence
//               detector: config handshake with length checking, arm/disarm
//               FSM and saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = C_MAX_LEN_DEF,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [MAX_LEN-1:0]       cfg_pattern,
  input  logic [$clog2(MAX_LEN):0] cfg_len,
  input  logic                     cfg_overlap,
  output logic                     cfg_err,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     in,
  input  logic                     in_valid,
  output logic                     out,
  output logic                     busy,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     cnt_sat
);

  localparam int unsigned      LEN_W     = $clog2(MAX_LEN) + 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_arm;
  logic                 w_xfer;
  logic                 w_len_ok;
  logic                 w_match;

  logic [MAX_LEN-1:0]   r_pattern;
  logic [LEN_W-1:0]     r_len;
  logic                 r_overlap;
  logic                 r_loaded;
  logic                 r_cfg_err;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sat;

  assign w_xfer   = cfg_valid & cfg_ready;
  assign w_len_ok = len_legal(32'(cfg_len), MAX_LEN);

  // State register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs. A config offer in IDLE takes
  // priority over start, whether or not that config turns out legal.
  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    cfg_ready   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (start && !cfg_valid && r_loaded) begin
          w_state_nxt = ST_RUN;
          w_arm       = 1'b1;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Config registers: a legal transfer overwrites them, an illegal one
  // leaves them alone and raises a one-cycle error pulse.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_loaded  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer & ~w_len_ok;
      if (w_xfer && w_len_ok) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_loaded  <= 1'b1;
      end
    end
  end

  seq_det_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .clk     (clk),
    .arstn   (arstn),
    .clr     (w_arm),
    .en      (busy & in_valid),
    .in      (in),
    .len     (r_len),
    .pattern (r_pattern),
    .overlap (r_overlap),
    .match   (w_match)
  );

  // Saturating match counter with sticky saturation flag, both cleared on arm
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_arm) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_match && (r_cnt != C_CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if ((r_cnt + CNT_W'(1)) == C_CNT_MAX) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign out       = w_match;
  assign cfg_err   = r_cfg_err;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seq_det_ctrl
// Description : Self-checking bench for seq_det_ctrl. Two instances share the
//               stimulus: one with an 8-bit counter and one with a 2-bit
//               counter so saturation is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

  localparam int ML = 8;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       din = 1'b0;
  logic       in_valid = 1'b0;

  logic       a_ready, a_err, a_out, a_busy, a_sat;
  logic [7:0] a_cnt;
  logic       b_ready, b_err, b_out, b_busy, b_sat;
  logic [1:0] b_cnt;

  always #5 clk = ~clk;

  seq_det_ctrl #(.MAX_LEN(ML), .CNT_W(8)) dut_a (
    .clk(clk), .arstn(arstn), .cfg_valid(cfg_valid), .cfg_ready(a_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(a_err), .start(start), .stop(stop), .in(din), .in_valid(in_valid),
    .out(a_out), .busy(a_busy), .match_cnt(a_cnt), .cnt_sat(a_sat)
  );

  seq_det_ctrl #(.MAX_LEN(ML), .CNT_W(2)) dut_b (
    .clk(clk), .arstn(arstn), .cfg_valid(cfg_valid), .cfg_ready(b_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(b_err), .start(start), .stop(stop), .in(din), .in_valid(in_valid),
    .out(b_out), .busy(b_busy), .match_cnt(b_cnt), .cnt_sat(b_sat)
  );

  // Reference model: a list of the qualified bits seen since arming (or since
  // the last non-overlapping match); a match is the tail of that list equal
  // to the pattern.
  bit       m_run, m_loaded, m_ovl, m_err;
  bit [7:0] m_pat;
  int       m_len;
  bit       seen[$];
  int       m_cnt8, m_cnt2;
  bit       m_sat8, m_sat2;

  int checks = 0;
  int errors = 0;

  function automatic bit model_match();
    bit w[$];
    if (!m_run || !in_valid) return 1'b0;
    w = seen;
    w.push_back(din);
    if (w.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (w[w.size() - m_len + i] != m_pat[m_len-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_loaded = 0; m_ovl = 0; m_err = 0; m_pat = '0; m_len = 0;
    seen.delete();
    m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 0; m_sat2 = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check every output mid-cycle, then advance the model.
  task automatic cycle();
    bit m_out, xfer, legal;
    @(negedge clk);
    m_out = model_match();
    chk("out_a",   32'(a_out),   32'(m_out));
    chk("out_b",   32'(b_out),   32'(m_out));
    chk("ready_a", 32'(a_ready), 32'(!m_run));
    chk("ready_b", 32'(b_ready), 32'(!m_run));
    chk("busy_a",  32'(a_busy),  32'(m_run));
    chk("busy_b",  32'(b_busy),  32'(m_run));
    chk("err_a",   32'(a_err),   32'(m_err));
    chk("err_b",   32'(b_err),   32'(m_err));
    chk("cnt_a",   32'(a_cnt),   32'(m_cnt8));
    chk("cnt_b",   32'(b_cnt),   32'(m_cnt2));
    chk("sat_a",   32'(a_sat),   32'(m_sat8));
    chk("sat_b",   32'(b_sat),   32'(m_sat2));
    xfer  = cfg_valid && !m_run;
    legal = (cfg_len >= 2) && (cfg_len <= ML);
    m_err = xfer && !legal;
    if (m_run) begin
      if (in_valid) begin
        seen.push_back(din);
        if (m_out && !m_ovl) seen.delete();
        while (seen.size() > ML) void'(seen.pop_front());
        if (m_out) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
          m_sat8 = m_sat8 || (m_cnt8 == 255);
          m_sat2 = m_sat2 || (m_cnt2 == 3);
        end
      end
      if (stop) m_run = 0;
    end else if (start && !cfg_valid && m_loaded) begin
      m_run = 1;
      seen.delete();
      m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 0; m_sat2 = 0;
    end
    if (xfer && legal) begin
      m_loaded = 1; m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic disarm();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  task automatic feed(input logic b);
    din = b; in_valid = 1'b1; cycle(); in_valid = 1'b0;
  endtask

  // Feed the n low bits of `bits`, most significant first
  task automatic feed_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) feed(bits[i]);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"},  32'(a_busy),  32'd0);
    chk({tag, "_ready"}, 32'(a_ready), 32'd1);
    chk({tag, "_out"},   32'(a_out),   32'd0);
    chk({tag, "_err"},   32'(a_err),   32'd0);
    chk({tag, "_cnt"},   32'(a_cnt),   32'd0);
    chk({tag, "_sat"},   32'(a_sat),   32'd0);
    chk({tag, "_cntb"},  32'(b_cnt),   32'd0);
  endtask

  initial begin
    model_reset();

    // Reset values while arstn is held low
    #12;
    check_reset_values("rst");
    @(posedge clk); #1;
    arstn = 1'b1;
    cycle();

    // Rejected lengths pulse cfg_err; start is ignored with nothing loaded
    send_cfg(8'h0B, 4'd0, 1'b1);
    chk("err_pulse_len0", 32'(a_err), 32'd1);
    send_cfg(8'h0B, 4'(ML + 1), 1'b1);
    chk("err_pulse_len9", 32'(a_err), 32'd1);
    cycle();
    chk("err_clears", 32'(a_err), 32'd0);
    arm();
    chk("start_no_cfg", 32'(a_busy), 32'd0);
    cycle();

    // Overlapping 1011: matches on bits 4 and 7
    send_cfg(8'h0B, 4'd4, 1'b1);
    arm();
    chk("arm_busy", 32'(a_busy), 32'd1);
    feed_bits(16'b1011011, 7);
    chk("ovl_cnt", 32'(a_cnt), 32'd2);

    // Config offered while armed is not taken
    cfg_valid = 1'b1; cfg_pattern = 8'h03; cfg_len = 4'd2;
    #1;
    chk("ready_busy", 32'(a_ready), 32'd0);
    cycle();
    cfg_valid = 1'b0;
    disarm();
    chk("stop_idle", 32'(a_busy), 32'd0);
    chk("cnt_hold", 32'(a_cnt), 32'd2);

    // Non-overlapping 1011: the shared bits cannot form a second match
    send_cfg(8'h0B, 4'd4, 1'b0);
    arm();
    chk("arm_clr_cnt", 32'(a_cnt), 32'd0);
    feed_bits(16'b1011011, 7);
    chk("novl_cnt1", 32'(a_cnt), 32'd1);
    feed_bits(16'b1011, 4);
    chk("novl_cnt2", 32'(a_cnt), 32'd2);
    disarm();

    // Qualification: gap cycles with toggling data are ignored
    send_cfg(8'h06, 4'd3, 1'b0);
    arm();
    for (int i = 2; i >= 0; i--) begin
      din = ~din; in_valid = 1'b0; cycle();
      din = ~din; cycle();
      feed(i != 0);
    end
    din = 1'b1; cycle();
    chk("qual_cnt", 32'(a_cnt), 32'd1);
    disarm();

    // Saturation of the 2-bit counter with overlapping 11
    send_cfg(8'h03, 4'd2, 1'b1);
    arm();
    for (int i = 0; i < 6; i++) feed(1'b1);
    chk("sat_cnt_b", 32'(b_cnt), 32'd3);
    chk("sat_flag_b", 32'(b_sat), 32'd1);
    chk("nosat_cnt_a", 32'(a_cnt), 32'd5);
    disarm();
    arm();
    chk("sat_clr_cnt", 32'(b_cnt), 32'd0);
    chk("sat_clr_flag", 32'(b_sat), 32'd0);
    disarm();

    // Reset mid-RUN during a partial match loses config and state
    send_cfg(8'h0B, 4'd4, 1'b1);
    arm();
    feed_bits(16'b101, 3);
    arstn = 1'b0;
    #2;
    check_reset_values("midrst");
    model_reset();
    @(posedge clk); #1;
    arstn = 1'b1;
    arm();
    chk("start_after_rst", 32'(a_busy), 32'd0);
    feed(1'b1);

    // Randomized traffic: short patterns, random control events
    for (int r = 0; r < 8; r++) begin
      send_cfg(8'($urandom), ($urandom_range(0, 9) == 0) ? 4'd9 : 4'($urandom_range(2, 4)),
               1'($urandom));
      arm();
      for (int c = 0; c < 80; c++) begin
        din       = 1'($urandom);
        in_valid  = ($urandom_range(0, 3) != 0);
        stop      = ($urandom_range(0, 49) == 0);
        start     = ($urandom_range(0, 9) == 0);
        cfg_valid = ($urandom_range(0, 19) == 0);
        cfg_pattern = 8'($urandom);
        cfg_len     = 4'($urandom_range(0, 5));
        cfg_overlap = 1'($urandom);
        cycle();
      end
      cfg_valid = 1'b0; start = 1'b0; in_valid = 1'b0;
      disarm();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
